// File: rtl/cdb_pkg.sv
// Shared types, widths and helpers for the common data bus arbiter.
// Source indices follow the functional-unit order seen by the reservation stations.
package cdb_pkg;

    localparam int NUM_SRC = 6;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;
    localparam int CNT_W   = 16;
    localparam int PTR_W   = 3;

    localparam logic [TAG_W-1:0] TAG_NONE = 4'h0;
    localparam logic [CNT_W-1:0] CNT_MAX  = 16'hFFFF;

    typedef enum logic [PTR_W-1:0] {
        SRC_ADD1  = 3'd0,
        SRC_ADD2  = 3'd1,
        SRC_ADD3  = 3'd2,
        SRC_MULT1 = 3'd3,
        SRC_MULT2 = 3'd4,
        SRC_MEM   = 3'd5
    } src_idx_e;

    // Index that lies 'off' places after 'base' in the circular source order.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input logic [PTR_W-1:0] off);
        logic [PTR_W:0] sum;
        sum = ({1'b0, base} + {1'b0, off}) % 4'd6;
        return sum[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Purely combinational round-robin selector: first requester at or after ptr wins.
// Produces both the one-hot grant and its encoded index.
module rr_arbiter
    import cdb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_SRC-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    logic             found_s;
    logic [PTR_W-1:0] idx_s;

    // Circular priority search starting from ptr.
    always_comb begin
        grant     = 6'b000000;
        grant_idx = 3'd0;
        found_s   = 1'b0;
        idx_s     = 3'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx_s = wrap_add(ptr, 3'(k));
            if (!found_s && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_idx    = idx_s;
                found_s      = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among six result sources and a
// one-cycle registered broadcast with a saturating count and tag-0 error flag.
module cdb_arbiter
    import cdb_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [NUM_SRC-1:0]              req_valid,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]  req_data,
    input  logic [NUM_SRC-1:0][TAG_W-1:0]   req_tag,
    output logic [NUM_SRC-1:0]              req_ready,
    output logic                            cdb_valid,
    output logic [DATA_W-1:0]               cdb_data,
    output logic [TAG_W-1:0]                cdb_tag,
    output logic [CNT_W-1:0]                bcast_count,
    output logic                            err_tag0
);

    logic [PTR_W-1:0]  ptr_r;
    logic [NUM_SRC-1:0] grant_s;
    logic [PTR_W-1:0]  grant_idx_s;
    logic [NUM_SRC-1:0] ready_s;
    logic              fire_s;
    logic              bcast_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [TAG_W-1:0]  sel_tag_s;

    logic              cdb_valid_r;
    logic [DATA_W-1:0] cdb_data_r;
    logic [TAG_W-1:0]  cdb_tag_r;
    logic [CNT_W-1:0]  bcast_count_r;
    logic              err_tag0_r;

    rr_arbiter u_rr (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Grant gating and one-hot selection of the winning source's payload.
    always_comb begin
        ready_s    = 6'b000000;
        sel_data_s = 32'h0000_0000;
        sel_tag_s  = 4'h0;
        if (rst || flush) begin
            ready_s = 6'b000000;
        end else begin
            ready_s = grant_s;
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ready_s[i]) begin
                sel_data_s = sel_data_s | req_data[i];
                sel_tag_s  = sel_tag_s | req_tag[i];
            end else begin
                sel_data_s = sel_data_s;
                sel_tag_s  = sel_tag_s;
            end
        end
        fire_s  = |ready_s;
        bcast_s = fire_s && (sel_tag_s != TAG_NONE);
    end

    // Pointer, broadcast register, saturating counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r         <= 3'd0;
            cdb_valid_r   <= 1'b0;
            cdb_data_r    <= 32'h0000_0000;
            cdb_tag_r     <= 4'h0;
            bcast_count_r <= 16'h0000;
            err_tag0_r    <= 1'b0;
        end else begin
            ptr_r       <= fire_s ? wrap_add(grant_idx_s, 3'd1) : ptr_r;
            cdb_valid_r <= bcast_s;
            cdb_data_r  <= bcast_s ? sel_data_s : 32'h0000_0000;
            cdb_tag_r   <= bcast_s ? sel_tag_s : 4'h0;
            if (bcast_s && (bcast_count_r != CNT_MAX)) begin
                bcast_count_r <= bcast_count_r + 16'd1;
            end else begin
                bcast_count_r <= bcast_count_r;
            end
            // Tag 0 is reserved for "no producer", so consuming one is an error.
            err_tag0_r <= err_tag0_r | (fire_s && (sel_tag_s == TAG_NONE));
        end
    end

    assign req_ready   = ready_s;
    assign cdb_valid   = cdb_valid_r;
    assign cdb_data    = cdb_data_r;
    assign cdb_tag     = cdb_tag_r;
    assign bcast_count = bcast_count_r;
    assign err_tag0    = err_tag0_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter; one task per scenario.
module tb_cdb_arbiter;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [5:0]        req_valid;
    logic [5:0][31:0]  req_data;
    logic [5:0][3:0]   req_tag;
    logic [5:0]        req_ready;
    logic              cdb_valid;
    logic [31:0]       cdb_data;
    logic [3:0]        cdb_tag;
    logic [15:0]       bcast_count;
    logic              err_tag0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    cdb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .cdb_valid   (cdb_valid),
        .cdb_data    (cdb_data),
        .cdb_tag     (cdb_tag),
        .bcast_count (bcast_count),
        .err_tag0    (err_tag0)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_default_payload();
        for (int i = 0; i < 6; i++) begin
            req_tag[i]  = 4'(i + 1);
            req_data[i] = 32'h1000_0000 + 32'(i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; req_valid = 6'b000000;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; req_valid = 6'b111111;
        load_default_payload();
        step();
        #1;
        total_cnt++;
        if (req_ready !== 6'b000000) $display("FAIL reset_ready: got %b want 000000", req_ready); else pass_cnt++;
        total_cnt++;
        if ({cdb_valid, cdb_data, cdb_tag} !== 37'd0) $display("FAIL reset_cdb: got v=%0b d=%h t=%h want 0", cdb_valid, cdb_data, cdb_tag); else pass_cnt++;
        total_cnt++;
        if ({bcast_count, err_tag0} !== 17'd0) $display("FAIL reset_cnt: got cnt=%h err=%0b want 0", bcast_count, err_tag0); else pass_cnt++;
        rst = 1'b0; req_valid = 6'b000000;
        step();
    endtask

    task automatic test_single();
        req_valid = 6'b001000; req_tag[3] = 4'h5; req_data[3] = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if (req_ready !== 6'b001000) $display("FAIL single_ready: got %b want 001000", req_ready); else pass_cnt++;
        step();
        req_valid = 6'b000000;
        total_cnt++;
        if ({cdb_valid, cdb_tag, cdb_data} !== {1'b1, 4'h5, 32'hDEAD_BEEF})
            $display("FAIL single_bcast: got v=%0b t=%h d=%h want 1 5 deadbeef", cdb_valid, cdb_tag, cdb_data);
        else pass_cnt++;
        // ptr should now be 4: with everyone requesting, source 4 wins.
        req_valid = 6'b111111;
        #1;
        total_cnt++;
        if (req_ready !== 6'b010000) $display("FAIL single_ptr: got %b want 010000", req_ready); else pass_cnt++;
        req_valid = 6'b000000;
        step();
        total_cnt++;
        if (cdb_valid !== 1'b0 || bcast_count !== 16'd1) $display("FAIL single_idle: got v=%0b cnt=%0d want 0 1", cdb_valid, bcast_count); else pass_cnt++;
    endtask

    task automatic test_fairness_back_to_back();
        int bad_grant = 0;
        int bad_bcast = 0;
        do_reset();
        load_default_payload();
        req_valid = 6'b111111;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (req_ready !== 6'(1 << (c % 6))) bad_grant++;
            step();
            if (cdb_valid !== 1'b1 || cdb_tag !== 4'(c % 6 + 1) || cdb_data !== 32'h1000_0000 + 32'(c % 6)) bad_bcast++;
        end
        req_valid = 6'b000000;
        total_cnt++;
        if (bad_grant !== 0) $display("FAIL fair_order: got %0d bad grants want 0", bad_grant); else pass_cnt++;
        total_cnt++;
        if (bad_bcast !== 0) $display("FAIL fair_bcast: got %0d bad broadcasts want 0", bad_bcast); else pass_cnt++;
        total_cnt++;
        if (bcast_count !== 16'd12) $display("FAIL fair_count: got %0d want 12", bcast_count); else pass_cnt++;
        step();
    endtask

    task automatic test_wrap();
        // ptr is 0 here; granting source 4 moves it to 5.
        req_valid = 6'b010000;
        step();
        req_valid = 6'b100001;
        #1;
        total_cnt++;
        if (req_ready !== 6'b100000) $display("FAIL wrap_first: got %b want 100000", req_ready); else pass_cnt++;
        step();
        req_valid = 6'b000001;
        #1;
        total_cnt++;
        if (req_ready !== 6'b000001 || cdb_tag !== 4'h6) $display("FAIL wrap_second: got %b t=%h want 000001 6", req_ready, cdb_tag); else pass_cnt++;
        step();
        req_valid = 6'b111111;
        #1;
        total_cnt++;
        if (req_ready !== 6'b000010) $display("FAIL wrap_ptr: got %b want 000010", req_ready); else pass_cnt++;
        req_valid = 6'b000000;
        step();
    endtask

    task automatic test_flush();
        // ptr is 1 here.
        req_valid = 6'b000110; flush = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 6'b000000) $display("FAIL flush_ready: got %b want 000000", req_ready); else pass_cnt++;
        step();
        flush = 1'b0;
        total_cnt++;
        if ({cdb_valid, cdb_data, cdb_tag} !== 37'd0) $display("FAIL flush_cdb: got v=%0b d=%h t=%h want 0", cdb_valid, cdb_data, cdb_tag); else pass_cnt++;
        #1;
        total_cnt++;
        if (req_ready !== 6'b000010) $display("FAIL flush_resume: got %b want 000010", req_ready); else pass_cnt++;
        step();
        req_valid = 6'b000000;
        total_cnt++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 4'h2 || bcast_count !== 16'd16)
            $display("FAIL flush_bcast: got v=%0b t=%h cnt=%0d want 1 2 16", cdb_valid, cdb_tag, bcast_count);
        else pass_cnt++;
        step();
    endtask

    task automatic test_tag0();
        // ptr is 2 here.
        req_valid = 6'b000100; req_tag[2] = 4'h0; req_data[2] = 32'h1234_5678;
        #1;
        total_cnt++;
        if (req_ready !== 6'b000100) $display("FAIL tag0_ready: got %b want 000100", req_ready); else pass_cnt++;
        step();
        req_valid = 6'b000000;
        total_cnt++;
        if ({cdb_valid, cdb_data, cdb_tag} !== 37'd0 || err_tag0 !== 1'b1 || bcast_count !== 16'd16)
            $display("FAIL tag0_result: got v=%0b d=%h err=%0b cnt=%0d want 0 0 1 16", cdb_valid, cdb_data, err_tag0, bcast_count);
        else pass_cnt++;
        step();
        total_cnt++;
        if (err_tag0 !== 1'b1) $display("FAIL tag0_sticky: got %0b want 1", err_tag0); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        total_cnt++;
        if (err_tag0 !== 1'b0) $display("FAIL sat_err_clear: got %0b want 0", err_tag0); else pass_cnt++;
        load_default_payload();
        req_valid = 6'b111111;
        for (int n = 0; n < 65534; n++) step();
        total_cnt++;
        if (bcast_count !== 16'hFFFE) $display("FAIL sat_near: got %h want fffe", bcast_count); else pass_cnt++;
        for (int n = 0; n < 6; n++) step();
        req_valid = 6'b000000;
        total_cnt++;
        if (bcast_count !== 16'hFFFF || cdb_valid !== 1'b1) $display("FAIL sat_hold: got cnt=%h v=%0b want ffff 1", bcast_count, cdb_valid); else pass_cnt++;
        step();
    endtask

    task automatic test_reset_midop();
        // 65540 grants leave ptr at 2, so source 3 would win over source 0.
        req_valid = 6'b001001;
        #1;
        total_cnt++;
        if (req_ready !== 6'b001000) $display("FAIL mid_pre: got %b want 001000", req_ready); else pass_cnt++;
        rst = 1'b1; flush = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 6'b000000) $display("FAIL mid_rst_ready: got %b want 000000", req_ready); else pass_cnt++;
        step();
        rst = 1'b0; flush = 1'b0;
        total_cnt++;
        if ({cdb_valid, bcast_count} !== 17'd0) $display("FAIL mid_rst_state: got v=%0b cnt=%0d want 0 0", cdb_valid, bcast_count); else pass_cnt++;
        #1;
        total_cnt++;
        if (req_ready !== 6'b000001) $display("FAIL mid_after: got %b want 000001", req_ready); else pass_cnt++;
        step();
        req_valid = 6'b000000;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 6'b000000;
        req_data = '0; req_tag = '0;
        test_reset();
        test_single();
        test_fairness_back_to_back();
        test_wrap();
        test_flush();
        test_tag0();
        test_saturation();
        test_reset_midop();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk in, rst in; all state SHALL update on the rising edge of clk only.
REQ-002 SHALL provide ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- flush  input  1  squash: no grant this cycle, clear broadcast register
- req_valid  input  6  per-source result pending. Index order: 0=adder1, 1=adder2, 2=adder3, 3=multi1, 4=multi2, 5=mem
- req_data  input  6x32  per-source result; multipliers supply the lower word only
- req_tag  input  6x4  per-source reservation-station tag
- req_ready  output  6  one-hot grant; the source's result is consumed this cycle
- cdb_valid  output  1  broadcast valid
- cdb_data  output  32  broadcast data
- cdb_tag  output  4  broadcast tag
- bcast_count  output  16  saturating count of broadcasts
- err_tag0  output  1  sticky flag: a tag-0 request was consumed

Function
REQ-003 SHALL assert at most one req_ready bit per cycle, and only for a source with req_valid=1.
REQ-004 SHALL compute req_ready combinationally from req_valid, the priority pointer and flush; a source SHALL hold valid, data and tag stable until granted, and its valid SHALL NOT depend on req_ready.
REQ-005 SHALL arbitrate round-robin: 3-bit pointer ptr (0..5) names the highest-priority source; the search order is ptr, ptr+1, ... wrapping 5->0.
REQ-006 After granting source i, ptr SHALL become (i+1) mod 6, so i=5 gives ptr=0; with no grant, ptr SHALL hold.
REQ-007 SHALL register the broadcast with 1-cycle latency: a grant in cycle N gives cdb_valid=1 with that source's data and tag in cycle N+1.
REQ-008 A cycle with no grant SHALL give cdb_valid=0, cdb_data=0 and cdb_tag=0 in the next cycle.
REQ-009 A granted request with tag 4'h0 SHALL be consumed but not broadcast (next cdb_valid=0); it SHALL set err_tag0, which stays set until rst.
REQ-010 With flush=1, all req_ready bits SHALL be 0, ptr SHALL hold, and the next cycle SHALL give cdb_valid=0, cdb_data=0 and cdb_tag=0. Requests SHALL remain pending at their sources.
REQ-011 bcast_count SHALL increment by 1 in the cycle cdb_valid is loaded with 1 and SHALL saturate at 16'hFFFF.
REQ-012 If flush and rst are both 1 in the same cycle, rst SHALL take precedence.
REQ-013 Back-to-back grants SHALL be possible every cycle; sustained throughput SHALL be one broadcast per cycle.
REQ-014 With all six sources valid continuously, each source SHALL be granted exactly once in every 6 consecutive grants.

Reset
REQ-015 On rst=1 at a clock edge, the following SHALL be loaded:
- ptr=0
- cdb_valid=0, cdb_data=0, cdb_tag=0
- bcast_count=0
- err_tag0=0
REQ-016 While rst=1, all req_ready bits SHALL be 0. A request pending across a mid-operation reset SHALL be granted after reset deasserts, with ptr starting from 0.

Structure
REQ-017 Shared package cdb_pkg SHALL hold:
- NUM_SRC=6, DATA_W=32, TAG_W=4, CNT_W=16
- TAG_NONE=4'h0
- enum src_idx_e (SRC_ADD1..SRC_MEM, values 0..5)
REQ-018 One sub-module, rr_arbiter, SHALL be used: purely combinational, inputs request vector and pointer, outputs one-hot grant and encoded index; ptr, the broadcast register and the counters SHALL stay in cdb_arbiter.

Verification
REQ-019 After reset, the bench SHALL check all outputs are 0 and req_ready=6'b0 during rst.
REQ-020 The bench SHALL cover these directed scenarios:
- Single source: only req_valid[3] with tag 4'h5, data 32'hDEAD_BEEF -> req_ready=6'b001000 in cycle N; cycle N+1 gives cdb_valid=1, cdb_tag=5, cdb_data=32'hDEADBEEF; ptr=4.
- Fairness: all six valid for 12 cycles with tags 1..6 -> grant order 0,1,2,3,4,5,0,...,5; bcast_count=12.
- Wrap: ptr=5 with sources 5 and 0 valid -> source 5 granted, then source 0; ptr ends at 1.
- Flush mid-stream: flush=1 for one cycle with sources 1 and 2 valid and ptr=1 -> no grant; next cdb_valid=0; the following cycle grants source 1.
- Tag-0 request: source 2 valid with tag 0 -> req_ready[2]=1; next cdb_valid=0; err_tag0=1; bcast_count unchanged.
- Saturation: bcast_count preloaded near max via 65540 grants -> holds at 16'hFFFF.
